// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage access block.
// The access FSM and its WAIT timeout counter both import this package.
package mem_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int TIMER_W     = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // A branch never sets either of these, so it never starts a memory access.
  function automatic logic is_access(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles for the data-memory handshake and flags when the limit is reached.
// Clear has priority over enable; the count parks at the limit instead of wrapping.
module mem_wait_timer
  import mem_stage_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LIMIT_VAL = TIMER_W'(LIMIT);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT_VAL);

endmodule

// File: rtl/mem_stage_access.sv
// MEM pipeline stage: issues req/ack data-memory accesses, stalls upstream until done,
// resolves the branch, and registers results into the MEM/WB outputs.
module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] sum_i,
  input  logic              zero_i,
  input  logic              Branch_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  output logic              PCSrc_o,
  output logic [DATA_W-1:0] BrTarget_o,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic              err_o
);

  mem_state_e state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              regWrite_q, regWrite_d;
  logic              memtoReg_q, memtoReg_d;
  logic [REG_AW-1:0] rdAddr_q, rdAddr_d;
  logic [DATA_W-1:0] aluResult_q, aluResult_d;
  logic [DATA_W-1:0] memData_q, memData_d;

  logic acc;
  logic stall;
  logic tmrClr;
  logic tmrEn;
  logic tmrExpired;

  assign acc = is_access(MemRead_i, MemWrite_i);

  mem_wait_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmrClr),
    .en_i     (tmrEn),
    .expired_o(tmrExpired)
  );

  // Access FSM; stall is combinational so upstream freezes in the issuing cycle itself.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmrClr  = 1'b0;
    tmrEn   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = ALUResult_i;
          wdata_d = RTdata_i;
          tmrClr  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ack_i) begin
          rdata_d = we_q ? '0 : dmem_rdata_i;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (tmrExpired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          tmrEn = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // MEM/WB register: follows EX/MEM when not stalled, otherwise inserts a writeback bubble.
  always_comb begin
    regWrite_d  = regWrite_q;
    memtoReg_d  = memtoReg_q;
    rdAddr_d    = rdAddr_q;
    aluResult_d = aluResult_q;
    memData_d   = memData_q;
    if (!stall) begin
      regWrite_d  = RegWrite_i;
      memtoReg_d  = MemtoReg_i;
      rdAddr_d    = RDaddr_i;
      aluResult_d = ALUResult_i;
      memData_d   = rdata_q;
    end else begin
      regWrite_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      regWrite_q  <= 1'b0;
      memtoReg_q  <= 1'b0;
      rdAddr_q    <= '0;
      aluResult_q <= '0;
      memData_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      regWrite_q  <= regWrite_d;
      memtoReg_q  <= memtoReg_d;
      rdAddr_q    <= rdAddr_d;
      aluResult_q <= aluResult_d;
      memData_q   <= memData_d;
    end
  end

  assign PCSrc_o      = Branch_i & zero_i;
  assign BrTarget_o   = sum_i;
  assign stall_o      = stall;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign RegWrite_o   = regWrite_q;
  assign MemtoReg_o   = memtoReg_q;
  assign RDaddr_o     = rdAddr_q;
  assign ALUResult_o  = aluResult_q;
  assign MemData_o    = memData_q;
  assign err_o        = err_q;

endmodule
